// File: rtl/chip_test_ctrl_pkg.sv
// Shared types and constants for the chip tester front-panel sequencer.
// Holds the FSM state encoding and the saturating count helper.
package chip_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        WAIT_DONE = 3'd2,
        SAMPLE    = 3'd3,
        SHOW      = 3'd4,
        RELEASE   = 3'd5,
        ERR       = 3'd6
    } ctrl_state_t;

    localparam logic [7:0] CNT_SAT = 8'hFF;

    function automatic logic [7:0] sat_inc(input logic [7:0] val);
        return (val == CNT_SAT) ? val : val + 8'd1;
    endfunction

endpackage

// File: rtl/chip_test_ctrl_if.sv
// Handshake between the sequencer and the chip tester it drives.
// The ctrl side issues Run/DISP_RSLT; the tester side returns Done/RSLT.
interface chip_test_ctrl_if;

    logic Run;
    logic DISP_RSLT;
    logic Done;
    logic RSLT;

    modport ctrl (
        output Run,
        output DISP_RSLT,
        input  Done,
        input  RSLT
    );

    modport tester (
        input  Run,
        input  DISP_RSLT,
        output Done,
        output RSLT
    );

endinterface

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: two-flop synchroniser followed by a stable-time filter.
// Produces the debounced level and a one-cycle strobe on its 0->1 edge.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 26
) (
    input  logic Clk,
    input  logic Reset,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // The level flips only once the synchronised input has disagreed with it
    // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/chip_test_ctrl.sv
// Front-panel sequencer for a chip tester: start button -> Run, wait for Done,
// show pass/fail for a fixed time, then release the tester with DISP_RSLT.
module chip_test_ctrl
    import chip_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned DISP_CYCLES     = 32,
    parameter int unsigned TIMEOUT_CYCLES  = 64,
    parameter int unsigned CNT_W           = 26
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start_btn,
    chip_test_ctrl_if.ctrl       tester_io,
    output logic                 Busy,
    output logic                 Pass_LED,
    output logic                 Fail_LED,
    output logic                 Err_LED,
    output logic [7:0]           Pass_count,
    output logic [7:0]           Fail_count
);

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             run_q, run_d;
    logic             disp_q, disp_d;
    logic             busy_q, busy_d;
    logic             pass_led_q, pass_led_d;
    logic             fail_led_q, fail_led_d;
    logic             err_led_q, err_led_d;
    logic [7:0]       pass_cnt_q, pass_cnt_d;
    logic [7:0]       fail_cnt_q, fail_cnt_d;
    logic             btn_level, btn_rise, start_evt;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_start_btn (
        .Clk    (Clk),
        .Reset  (Reset),
        .btn_i  (Start_btn),
        .level_o(btn_level),
        .rise_o (btn_rise)
    );

    assign start_evt = btn_rise & btn_level;
    assign cnt_inc   = cnt_q + CNT_W'(1);

    // Outputs are computed from the next state so every one leaves a flop.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        run_d      = 1'b0;
        disp_d     = 1'b0;
        pass_led_d = pass_led_q;
        fail_led_d = fail_led_q;
        err_led_d  = err_led_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start_evt) begin
                    state_d    = ARM;
                    run_d      = 1'b1;
                    cnt_d      = '0;
                    pass_led_d = 1'b0;
                    fail_led_d = 1'b0;
                    err_led_d  = 1'b0;
                end
            end
            ARM: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (tester_io.Done) begin
                    state_d = SAMPLE;
                end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = ERR;
                    cnt_d      = cnt_inc;
                    err_led_d  = 1'b1;
                    disp_d     = 1'b1;
                    fail_cnt_d = sat_inc(fail_cnt_q);
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            SAMPLE: begin
                // RSLT is valid one cycle after Done rises; a dropped Done is a glitch.
                if (tester_io.Done) begin
                    state_d    = SHOW;
                    cnt_d      = '0;
                    pass_led_d = tester_io.RSLT;
                    fail_led_d = ~tester_io.RSLT;
                    if (tester_io.RSLT) begin
                        pass_cnt_d = sat_inc(pass_cnt_q);
                    end else begin
                        fail_cnt_d = sat_inc(fail_cnt_q);
                    end
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            SHOW: begin
                cnt_d = cnt_inc;
                if (cnt_inc == CNT_W'(DISP_CYCLES - 1)) begin
                    state_d = RELEASE;
                    disp_d  = 1'b1;
                end
            end
            RELEASE: begin
                if (tester_io.Done) begin
                    disp_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ERR: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_d = (state_d != IDLE);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            run_q      <= 1'b0;
            disp_q     <= 1'b0;
            busy_q     <= 1'b0;
            pass_led_q <= 1'b0;
            fail_led_q <= 1'b0;
            err_led_q  <= 1'b0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            run_q      <= run_d;
            disp_q     <= disp_d;
            busy_q     <= busy_d;
            pass_led_q <= pass_led_d;
            fail_led_q <= fail_led_d;
            err_led_q  <= err_led_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign tester_io.Run       = run_q;
    assign tester_io.DISP_RSLT = disp_q;
    assign Busy                = busy_q;
    assign Pass_LED            = pass_led_q;
    assign Fail_LED            = fail_led_q;
    assign Err_LED             = err_led_q;
    assign Pass_count          = pass_cnt_q;
    assign Fail_count          = fail_cnt_q;

endmodule

// File: tb/tb_chip_test_ctrl.sv
// Scoreboard bench for chip_test_ctrl: stimulus queues expected panel events,
// a negedge monitor pops and compares them as Run, DISP_RSLT and Busy move.
module tb_chip_test_ctrl;

    localparam int K_RUN  = 0;
    localparam int K_DISP = 1;
    localparam int K_IDLE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       busy, pl, fl, el;
    logic [7:0] pc, fc;

    chip_test_ctrl_if tif();

    always #5 clk = ~clk;

    chip_test_ctrl dut (
        .Clk       (clk),
        .Reset     (rst),
        .Start_btn (btn),
        .tester_io (tif),
        .Busy      (busy),
        .Pass_LED  (pl),
        .Fail_LED  (fl),
        .Err_LED   (el),
        .Pass_count(pc),
        .Fail_count(fc)
    );

    typedef struct {
        int kind;
        int cyc;
        int pl;
        int fl;
        int el;
        int pc;
        int fc;
        int dw;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   tester_mode = 0;  // 0: never Done, 1: pass, 2: fail, 3: pass + press during SHOW
    int   exp_pass = 0;
    int   exp_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input int p, input int f, input int e,
                        input int dw);
        exp_t x;
        x.kind = kind;
        x.cyc  = c;
        x.pl   = p;
        x.fl   = f;
        x.el   = e;
        x.pc   = exp_pass;
        x.fc   = exp_fail;
        x.dw   = dw;
        exp_q.push_back(x);
    endtask

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    // Monitor
    int   run_len = 0, disp_len = 0, disp_w_exp = 0;
    logic run_p = 1'b0, disp_p = 1'b0, busy_p = 1'b0;

    task automatic observe(input int kind, input string nm);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_%s: got an event, expected none (cycle %0d)", nm, cyc);
        end else begin
            e = exp_q.pop_front();
            check({nm, "_kind"}, kind, e.kind);
            check({nm, "_cycle"}, cyc, e.cyc);
            check({nm, "_pass_led"}, int'(pl), e.pl);
            check({nm, "_fail_led"}, int'(fl), e.fl);
            check({nm, "_err_led"}, int'(el), e.el);
            check({nm, "_pass_count"}, int'(pc), e.pc);
            check({nm, "_fail_count"}, int'(fc), e.fc);
            if (kind == K_DISP) disp_w_exp = e.dw;
        end
    endtask

    always @(negedge clk) begin
        if (tif.Run) run_len = run_p ? run_len + 1 : 1;
        if (tif.DISP_RSLT) disp_len = disp_p ? disp_len + 1 : 1;
        if (!tif.Run && run_p) check("run_width", run_len, 1);
        if (!tif.DISP_RSLT && disp_p) check("disp_width", disp_len, disp_w_exp);
        if (tif.Run && !run_p) observe(K_RUN, "run");
        if (tif.DISP_RSLT && !disp_p) observe(K_DISP, "disp");
        if (!busy && busy_p) observe(K_IDLE, "idle");
        run_p  = tif.Run;
        disp_p = tif.DISP_RSLT;
        busy_p = busy;
    end

    // Tester model: Done 6 cycles after Run, RSLT one cycle later, Done drops 3 cycles
    // after DISP_RSLT is seen.
    initial begin
        tif.Done = 1'b0;
        tif.RSLT = 1'b0;
        forever begin
            @(negedge clk);
            if (tif.Run && tester_mode != 0) begin
                repeat (6) @(negedge clk);
                tif.Done = 1'b1;
                @(negedge clk);
                tif.RSLT = (tester_mode != 2);
            end else if (tif.DISP_RSLT && tif.Done) begin
                repeat (3) @(negedge clk);
                tif.Done = 1'b0;
                tif.RSLT = 1'b0;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_run"}, int'(tif.Run), 0);
        check({tag, "_disp"}, int'(tif.DISP_RSLT), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_pass_led"}, int'(pl), 0);
        check({tag, "_fail_led"}, int'(fl), 0);
        check({tag, "_err_led"}, int'(el), 0);
        check({tag, "_pass_count"}, int'(pc), 0);
        check({tag, "_fail_count"}, int'(fc), 0);
        check({tag, "_state_idle"}, int'(dut.state_q), 0);
    endtask

    // One full test cycle. Run appears 2 (sync) + 16 (debounce) + 1 (FSM) cycles
    // after the stable press edge.
    task automatic do_run(input int mode, input bit bounce);
        int t0, r;
        bit pass;
        tester_mode = mode;
        if (bounce) begin
            for (int i = 0; i < 5; i++) begin
                btn = 1'b1;
                repeat (3) @(negedge clk);
                btn = 1'b0;
                repeat (3) @(negedge clk);
            end
        end
        @(negedge clk);
        btn = 1'b1;
        t0  = cyc;
        r   = t0 + 19;
        push(K_RUN, r, 0, 0, 0, 0);
        if (mode == 0) begin
            exp_fail = sat(exp_fail);
            push(K_DISP, r + 64, 0, 0, 1, 1);
            push(K_IDLE, r + 65, 0, 0, 1, 0);
        end else begin
            pass = (mode != 2);
            if (pass) exp_pass = sat(exp_pass);
            else exp_fail = sat(exp_fail);
            push(K_DISP, r + 39, int'(pass), int'(!pass), 0, 4);
            push(K_IDLE, r + 43, int'(pass), int'(!pass), 0, 0);
        end
        if (mode == 3) begin
            repeat (17) @(negedge clk);
            btn = 1'b0;
            while (cyc < t0 + 37) @(negedge clk);
            btn = 1'b1;  // debounced edge lands while the result is on display
            repeat (20) @(negedge clk);
            btn = 1'b0;
        end else begin
            repeat (20) @(negedge clk);
            btn = 1'b0;
        end
        while (cyc < t0 + 110) @(negedge clk);
    endtask

    initial begin
        int t0, r;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        do_run(1, 1'b1);
        do_run(2, 1'b0);
        do_run(0, 1'b0);
        do_run(3, 1'b0);
        for (int i = 0; i < 256; i++) do_run(1, 1'b0);

        // Asynchronous reset while waiting for Done.
        tester_mode = 0;
        @(negedge clk);
        btn = 1'b1;
        t0  = cyc;
        r   = t0 + 19;
        push(K_RUN, r, 0, 0, 0, 0);
        exp_pass = 0;
        exp_fail = 0;
        push(K_IDLE, r + 11, 0, 0, 0, 0);
        repeat (20) @(negedge clk);
        btn = 1'b0;
        while (cyc < r + 10) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("midrun_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        do_run(1, 1'b0);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/chip_test_ctrl.md
Name: chip_test_ctrl

Overview:
- Front-panel sequencer that sits directly upstream and downstream of a chip tester (e.g. chip_7402).
- Debounces the start pushbutton and issues a one-cycle Run pulse to the tester, then waits for Done.
- Samples RSLT, drives pass/fail indicators for a fixed display time, then pulses DISP_RSLT to return the tester to Halted.
- Flags a timeout if Done never arrives, e.g. no chip fitted or a wiring fault.

Parameters:
- DEBOUNCE_CYCLES, 16, cycles the Start_btn level must stay stable before it is accepted; hardware build overrides to 500000.
- DISP_CYCLES, 32, cycles the result is shown before the tester is released; hardware override 50000000.
- TIMEOUT_CYCLES, 64, maximum cycles from Run pulse to Done before ERR is entered.
- CNT_W, 26, width of the shared cycle counter; must hold max(DEBOUNCE_CYCLES, DISP_CYCLES, TIMEOUT_CYCLES).

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- Start_btn  in  1  raw pushbutton, active-high, asynchronous to Clk
- Done  in  1  tester Done
- RSLT  in  1  tester result, 1 = pass
- Run  out  1  start pulse to the tester
- DISP_RSLT  out  1  result-consumed acknowledge to the tester
- Busy  out  1  high in every state except IDLE
- Pass_LED  out  1  result shown as pass
- Fail_LED  out  1  result shown as fail
- Err_LED  out  1  timeout indicator
- Pass_count  out  8  number of passing tests, saturating
- Fail_count  out  8  number of failing and timed-out tests, saturating

Behaviour:
- Reset (asynchronous): state IDLE; all 1-bit outputs 0; both counts 0; counter 0; synchroniser flops 0.
- Start_btn passes through a 2-flop synchroniser, then the debouncer.
  - The debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - A start event is the debounced 0->1 edge; it is a one-cycle internal strobe.
- State machine: IDLE, ARM, WAIT_DONE, SAMPLE, SHOW, RELEASE, ERR.
- IDLE: on a start event go to ARM. Pass_LED and Fail_LED keep the previous result until the next ARM.
- ARM: Run=1 for exactly this one cycle; clear Pass_LED, Fail_LED and Err_LED; clear the counter; go to WAIT_DONE.
- WAIT_DONE:
  - On Done=1, go to SAMPLE.
  - Otherwise increment the counter; when it reaches TIMEOUT_CYCLES-1 with Done still 0, go to ERR.
  - Done wins if Done=1 arrives in the same cycle as the timeout.
- SAMPLE: one-cycle wait, because the tester's RSLT is registered one cycle after Done rises.
  - If Done=1, latch RSLT: set Pass_LED=RSLT and Fail_LED=~RSLT; increment Pass_count or Fail_count (saturate at 255); clear the counter; go to SHOW.
  - If Done=0 (glitch), go to WAIT_DONE without touching the counts.
- SHOW: LEDs held; count to DISP_CYCLES-1, then go to RELEASE.
- RELEASE:
  - DISP_RSLT=1 while in this state; go to IDLE on the first cycle Done=0 is sampled.
  - DISP_RSLT must not stay high in IDLE.
- ERR: Err_LED=1; Fail_count increments once on entry; DISP_RSLT=1 for one cycle on entry; then go to IDLE (Err_LED stays set until the next ARM).
- Start events outside IDLE are ignored and not queued.
- Busy = (state != IDLE), registered.
- All outputs are registered; Run and DISP_RSLT never glitch.
- Reset mid-operation drops Run and DISP_RSLT immediately. Resetting the tester is the top level's job (shared Reset).

Decomposition:
- Package chip_ctrl_pkg:
  - ctrl_state_t enum, 3 bits: IDLE, ARM, WAIT_DONE, SAMPLE, SHOW, RELEASE, ERR.
  - CNT_SAT constant = 8'hFF.
- One sub-module, btn_debounce: synchroniser plus stable counter, parameter DEBOUNCE_CYCLES, outputs the level and the rise strobe. It is reused for other panel buttons.
- Counters and FSM stay in chip_test_ctrl.

Test Plan:
- Bounce Start_btn 5 times at 3-cycle spacing, then hold high 20 cycles -> exactly one Run pulse, 1 cycle wide, asserted 2+16+1 cycles after the stable edge.
- Tester model raises Done 6 cycles after Run and RSLT=1 one cycle later -> Pass_LED=1, Fail_LED=0, Pass_count=1. DISP_RSLT rises 32 cycles after SAMPLE and holds until Done falls; then Busy=0.
- Same stimulus with RSLT=0 -> Fail_LED=1, Fail_count=1, Pass_count unchanged.
- Done never asserted -> ERR at Run+64 cycles; Err_LED=1; Fail_count increments once; one-cycle DISP_RSLT; return to IDLE.
- Start pressed during SHOW -> no second Run; 256 passing runs -> Pass_count stays at 255.
- Reset asserted during WAIT_DONE, asynchronously between edges -> Run, DISP_RSLT, LEDs and counts read 0 immediately; FSM in IDLE.
